// File: rtl/ps2_keyboard_fifo.sv
// ps2_keyboard_fifo
//   PS/2 keyboard receiver. Synchronises the raw ps2_clk/ps2_data pads,
//   deserialises 11-bit frames (start, 8 data bits LSB first, odd parity,
//   stop), folds the E0 (extended) and F0 (break) prefixes into per-event
//   flags, and queues {ext, break, code} events in a FIFO that is read
//   through a valid/ready handshake.
//
//   Build option: define PS2_TIMEOUT_EN to add a watchdog that abandons a
//   partial frame after TIMEOUT_CYCLES clk cycles without a ps2_clk fall.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   ps2_clk, ps2_data     raw PS/2 pad inputs
//   out_valid/out_ready   head-of-FIFO handshake (pop on valid && ready)
//   out_code/break/ext    head entry fields (0 while empty)
//   fifo_count            current occupancy, 0..DEPTH
//   press_count           make events accepted into the FIFO (wraps)
//   frame_err             one-cycle pulse on a bad (or abandoned) frame
//   overflow/overflow_clr sticky dropped-event flag and its clear
module ps2_keyboard_fifo #(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_code,
    output logic                     out_break,
    output logic                     out_ext,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         press_count,
    output logic                     frame_err,
    output logic                     overflow,
    input  logic                     overflow_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   brk_pend_q, brk_pend_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       press_q, press_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic [9:0]             mem_q [DEPTH];

    logic       sample, bit_in, stop_sample, good;
    logic [7:0] byte_v;
    logic       push, pop, full, empty, accept, drop, timeout;
    logic [9:0] head;

    // Sample on a 1->0 of the two oldest clock stages; data is taken from
    // the stage aligned with the newer clock stage so both see the same edge.
    assign sample = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign bit_in = data_sync_q[SYNC_STAGES-2];

    // After ten shifts, shift_q[0] holds the start bit, [8:1] the data
    // byte and [9] the parity bit; the stop bit is the live sample.
    assign stop_sample = sample && (bit_cnt_q == 4'd10);
    assign byte_v      = shift_q[8:1];
    assign good        = ~shift_q[0] & bit_in & (^shift_q[9:1]);
    assign push        = stop_sample && good && (byte_v != 8'hE0) && (byte_v != 8'hF0);

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

`ifdef PS2_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;

    // Fires once: clearing the bit counter stops the idle counter.
    assign timeout = !sample && (bit_cnt_q != 4'd0) && (idle_q == IW'(TIMEOUT_CYCLES));

    always_comb begin
        idle_d = idle_q;
        if (sample)
            idle_d = '0;
        else if ((bit_cnt_q != 4'd0) && (idle_q != IW'(TIMEOUT_CYCLES)))
            idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        frame_err_d = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        press_d     = press_q;
        overflow_d  = overflow_q;

        if (sample) begin
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!good) begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end else if (byte_v == 8'hE0) begin
                    ext_pend_d = 1'b1;
                end else if (byte_v == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {bit_in, shift_q[9:1]};
            end
        end else if (timeout) begin
            bit_cnt_d   = 4'd0;
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
        end

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!brk_pend_q)
                press_d = press_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            overflow_d = 1'b1;
        else if (overflow_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            press_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            press_q     <= press_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept)
            mem_q[wr_ptr_q[AW-1:0]] <= {ext_pend_q, brk_pend_q, byte_v};
    end

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid   = !empty;
    assign out_code    = out_valid ? head[7:0] : 8'h00;
    assign out_break   = out_valid & head[8];
    assign out_ext     = out_valid & head[9];
    assign fifo_count  = wr_ptr_q - rd_ptr_q;
    assign press_count = press_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
module tb_ps2_keyboard_fifo;
    localparam int DEPTH = 8;
    localparam int SYNC  = 3;
    localparam int CNT_W = 8;
    localparam int TO    = 300;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic out_valid, out_ready = 1'b0;
    logic [7:0] out_code;
    logic out_break, out_ext;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0] press_count;
    logic frame_err, overflow, overflow_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of expected {ext, break, code} entries.
    logic [9:0] exp_q[$];
    bit m_ext = 0, m_brk = 0, m_ovf = 0;
    int m_press = 0;

    always #5 clk = ~clk;

    ps2_keyboard_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_break(out_break), .out_ext(out_ext), .fifo_count(fifo_count),
        .press_count(press_count), .frame_err(frame_err), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_press = 0;
    endtask

    // Applies one received byte to the model, assuming no concurrent pops.
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back({m_ext, m_brk, b});
                if (!m_brk) m_press = m_press + 1;
            end else m_ovf = 1;
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Drives nbits of a frame; counts frame_err cycles while ps2_clk is low.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_push, output int errs);
        errs = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); ps2_data = bits[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                if (pop_at_push && i == 10 && j == SYNC - 1) out_ready = 1'b1;
                if (pop_at_push && i == 10 && j == SYNC) out_ready = 1'b0;
                if (frame_err) errs++;
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom);
        return b;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_code, out_break, out_ext, fifo_count, press_count, frame_err, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b code=%h brk=%b ext=%b cnt=%0d press=%0d ferr=%b ovf=%b, want all 0",
                     out_valid, out_code, out_break, out_ext, fifo_count, press_count, frame_err, overflow);
        end
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_make();
        int errs;
        logic [10:0] f;
        f = mk_frame(8'h1C, 0, 0);
        out_ready = 1'b1;
        send_bits(f, 10, 0, errs);
        @(negedge clk); ps2_data = f[10];
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        for (int j = 1; j <= SYNC + 1; j++) begin
            @(negedge clk);
            if (j == SYNC - 1) begin
                n_cmp++;
                if (out_valid !== 1'b0 || fifo_count !== 0) begin
                    n_bad++;
                    $display("FAIL make_early: valid=%b cnt=%0d, want 0/0", out_valid, fifo_count);
                end
            end
            if (j == SYNC) begin
                n_cmp++;
                if ({out_valid, out_ext, out_break, out_code} !== {3'b100, 8'h1C}) begin
                    n_bad++;
                    $display("FAIL make_head: got v=%b e=%b b=%b code=%h, want v=1 e=0 b=0 code=1c",
                             out_valid, out_ext, out_break, out_code);
                end
            end
            if (j == SYNC + 1) begin
                n_cmp++;
                if (out_valid !== 1'b0 || press_count !== 8'd1) begin
                    n_bad++;
                    $display("FAIL make_pop: valid=%b press=%0d, want 0 and 1", out_valid, press_count);
                end
            end
        end
        ps2_clk = 1'b1;
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        model_byte(8'h1C, 1);
        void'(exp_q.pop_front());
    endtask

    task automatic test_prefixes();
        int errs;
        logic [7:0] seq [6] = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75, 8'h75};
        logic [9:0] e;
        for (int i = 0; i < 6; i++) begin
            send_bits(mk_frame(seq[i], 0, 0), 11, 0, errs);
            model_byte(seq[i], 1);
        end
        n_cmp++;
        if (fifo_count !== 3 || press_count !== 8'(m_press)) begin
            n_bad++;
            $display("FAIL prefix_count: cnt=%0d press=%0d, want 3 and %0d", fifo_count, press_count, m_press);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({out_valid, out_ext, out_break, out_code} !== {1'b1, e}) begin
                n_bad++;
                $display("FAIL prefix_entry: got v=%b e=%b b=%b code=%h, want v=1 e=%b b=%b code=%h",
                         out_valid, out_ext, out_break, out_code, e[9], e[8], e[7:0]);
            end
            out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        end
    endtask

    task automatic test_bad_frames();
        int errs;
        logic [9:0] e;
        send_bits(mk_frame(8'hE0, 0, 0), 11, 0, errs); model_byte(8'hE0, 1);
        send_bits(mk_frame(8'h1C, 1, 0), 11, 0, errs); model_byte(8'h1C, 0);
        n_cmp++;
        if (errs !== 1 || fifo_count !== 0) begin
            n_bad++;
            $display("FAIL bad_parity: err_cycles=%0d cnt=%0d, want 1 and 0", errs, fifo_count);
        end
        send_bits(mk_frame(8'hF0, 0, 0), 11, 0, errs); model_byte(8'hF0, 1);
        send_bits(mk_frame(8'h1C, 0, 1), 11, 0, errs); model_byte(8'h1C, 0);
        n_cmp++;
        if (errs !== 1 || fifo_count !== 0) begin
            n_bad++;
            $display("FAIL bad_stop: err_cycles=%0d cnt=%0d, want 1 and 0", errs, fifo_count);
        end
        // Pends must have been cleared by the bad frames.
        send_bits(mk_frame(8'h1C, 0, 0), 11, 0, errs); model_byte(8'h1C, 1);
        e = exp_q.pop_front();
        n_cmp++;
        if (errs !== 0 || {out_valid, out_ext, out_break, out_code} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL bad_pend_clear: errs=%0d v=%b e=%b b=%b code=%h, want 0 1 %b %b %h",
                     errs, out_valid, out_ext, out_break, out_code, e[9], e[8], e[7:0]);
        end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int errs, p0;
        logic [7:0] b;
        logic [9:0] e;
        p0 = m_press;
        for (int i = 0; i <= DEPTH; i++) begin
            b = rand_code();
            send_bits(mk_frame(b, 0, 0), 11, 0, errs);
            model_byte(b, 1);
        end
        n_cmp++;
        if (fifo_count !== DEPTH || overflow !== 1'b1 || press_count !== 8'(p0 + DEPTH)) begin
            n_bad++;
            $display("FAIL ovf_full: cnt=%0d ovf=%b press=%0d, want %0d 1 %0d",
                     fifo_count, overflow, press_count, DEPTH, 8'(p0 + DEPTH));
        end
        @(negedge clk); overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0; m_ovf = 0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        // Push into a full FIFO in the same cycle as a pop.
        b = rand_code();
        send_bits(mk_frame(b, 0, 0), 11, 1, errs);
        void'(exp_q.pop_front());
        model_byte(b, 1);
        n_cmp++;
        if (fifo_count !== DEPTH || overflow !== 1'b0 || press_count !== 8'(m_press)) begin
            n_bad++;
            $display("FAIL full_push_pop: cnt=%0d ovf=%b press=%0d, want %0d 0 %0d",
                     fifo_count, overflow, press_count, DEPTH, 8'(m_press));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({out_valid, out_ext, out_break, out_code} !== {1'b1, e}) begin
                n_bad++;
                $display("FAIL ovf_drain: got v=%b e=%b b=%b code=%h, want v=1 e=%b b=%b code=%h",
                         out_valid, out_ext, out_break, out_code, e[9], e[8], e[7:0]);
            end
            out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        end
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_count !== 0) begin
            n_bad++;
            $display("FAIL ovf_empty: valid=%b cnt=%0d, want 0 0", out_valid, fifo_count);
        end
    endtask

    task automatic test_random();
        int errs, n, r;
        bit good;
        logic [7:0] b;
        logic [9:0] e;
        for (int round = 0; round < 4; round++) begin
            n = $urandom_range(DEPTH + 3, 1);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(9, 0);
                b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : rand_code();
                good = !(r == 2 || r == 3);
                send_bits(mk_frame(b, r == 2, r == 3), 11, 0, errs);
                model_byte(b, good);
                n_cmp++;
                if (errs !== (good ? 0 : 1)) begin
                    n_bad++;
                    $display("FAIL rand_ferr: byte=%h err_cycles=%0d want %0d", b, errs, good ? 0 : 1);
                end
            end
            n_cmp++;
            if (fifo_count !== exp_q.size() || press_count !== 8'(m_press) || overflow !== m_ovf) begin
                n_bad++;
                $display("FAIL rand_state: cnt=%0d press=%0d ovf=%b, want %0d %0d %b",
                         fifo_count, press_count, overflow, exp_q.size(), 8'(m_press), m_ovf);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({out_valid, out_ext, out_break, out_code} !== {1'b1, e}) begin
                    n_bad++;
                    $display("FAIL rand_entry: got v=%b e=%b b=%b code=%h, want v=1 e=%b b=%b code=%h",
                             out_valid, out_ext, out_break, out_code, e[9], e[8], e[7:0]);
                end
                out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
            end
            overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0; m_ovf = 0;
        end
    endtask

    task automatic test_reset_midframe();
        int errs;
        logic [9:0] e;
        send_bits(mk_frame(8'h55, 0, 0), 5, 0, errs);
        reset = 1'b1; repeat (3) @(negedge clk); reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        send_bits(mk_frame(8'h2A, 0, 0), 11, 0, errs);
        model_byte(8'h2A, 1);
        e = exp_q.pop_front();
        n_cmp++;
        if (errs !== 0 || fifo_count !== 1 || press_count !== 8'd1 ||
            {out_valid, out_ext, out_break, out_code} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL reset_midframe: errs=%0d cnt=%0d press=%0d v=%b e=%b b=%b code=%h, want 0 1 1 1 0 0 2a",
                     errs, fifo_count, press_count, out_valid, out_ext, out_break, out_code);
        end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

`ifdef PS2_TIMEOUT_EN
    task automatic test_timeout();
        int errs, pulses;
        logic [9:0] e;
        send_bits(mk_frame(8'hE0, 0, 0), 11, 0, errs); model_byte(8'hE0, 1);
        send_bits(mk_frame(8'h1C, 0, 0), 4, 0, errs);
        pulses = 0;
        for (int c = 0; c < TO + 50; c++) begin
            @(negedge clk);
            if (frame_err) pulses++;
        end
        model_byte(8'h00, 0);
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL timeout_err: err_cycles=%0d want 1", pulses);
        end
        send_bits(mk_frame(8'h1C, 0, 0), 11, 0, errs); model_byte(8'h1C, 1);
        e = exp_q.pop_front();
        n_cmp++;
        if (errs !== 0 || {out_valid, out_ext, out_break, out_code} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL timeout_next: errs=%0d v=%b e=%b b=%b code=%h, want 0 1 %b %b %h",
                     errs, out_valid, out_ext, out_break, out_code, e[9], e[8], e[7:0]);
        end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_make();
        test_prefixes();
        test_bad_frames();
        test_overflow();
        test_random();
        test_reset_midframe();
`ifdef PS2_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard bound on run time in case the bench itself stalls.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule
